// File: rtl/enc_pkg.sv
// Shared types and helpers for the synchronised 8-to-3 priority encoder.
// Holds the debouncer state encoding and the combinational encoder.
package enc_pkg;

  localparam int N_IN               = 8;
  localparam int CODE_W             = 3;
  localparam int DEB_CYCLES_DEFAULT = 1000000;

  typedef enum logic {
    DEB_STABLE,
    DEB_COUNT
  } deb_state_t;

  // Returns {valid, code}; ascending scan lets the highest set bit win.
  function automatic logic [CODE_W:0] prio_enc8(
    input logic [N_IN-1:0] v
  );
    logic [CODE_W:0] r;
    r = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (v[i]) r = {1'b1, i[CODE_W-1:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_vec.sv
// Two-flop synchroniser plus whole-vector debouncer.
// stable_vec only follows q2 after DEB_CYCLES quiet cycles.
module debounce_vec #(
  parameter int N_IN       = 8,
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] in_raw,
  output logic [N_IN-1:0] stable_vec
);

  import enc_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

  logic [N_IN-1:0]  q1, q2;
  logic [N_IN-1:0]  cand_q, cand_d;
  logic [N_IN-1:0]  stab_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  deb_state_t       state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q1         <= '0;
      q2         <= '0;
      cand_q     <= '0;
      cnt_q      <= '0;
      stable_vec <= '0;
      state_q    <= DEB_STABLE;
    end else begin
      q1         <= in_raw;
      q2         <= q1;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      stable_vec <= stab_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    stab_d  = stable_vec;
    unique case (state_q)
      DEB_STABLE: begin
        if (q2 != cand_q) begin
          cand_d  = q2;
          cnt_d   = '0;
          state_d = DEB_COUNT;
        end
      end
      DEB_COUNT: begin
        // Any movement restarts the quiet period.
        if (q2 != cand_q) begin
          cand_d = q2;
          cnt_d  = '0;
        end else if (cnt_q == LAST) begin
          stab_d  = cand_q;
          state_d = DEB_STABLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = DEB_STABLE;
    endcase
  end

endmodule

// File: rtl/enc_8to3_sync.sv
// Registered 8-to-3 priority encoder on debounced board inputs,
// with a change pulse and a sticky event flag cleared by ack.
module enc_8to3_sync
  import enc_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int CNT_W      = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   in_raw,
  input  logic              ack,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              evt,
  output logic              evt_pending,
  output logic [N_IN-1:0]   stable_vec
);

  logic [CODE_W:0] enc;
  logic            evt_d;

  debounce_vec #(
    .N_IN       (N_IN),
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_deb (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_raw     (in_raw),
    .stable_vec (stable_vec)
  );

  assign enc   = prio_enc8(stable_vec);
  assign evt_d = (enc != {valid, code});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code        <= '0;
      valid       <= 1'b0;
      evt         <= 1'b0;
      evt_pending <= 1'b0;
    end else begin
      code        <= enc[CODE_W-1:0];
      valid       <= enc[CODE_W];
      evt         <= evt_d;
      // An ack coinciding with a fresh event must not drop it.
      evt_pending <= evt_d | (evt_pending & ~(ack & ~evt));
    end
  end

endmodule

// File: tb/tb_enc_8to3_sync.sv
// Scoreboard bench for enc_8to3_sync with a short debounce window.
// Expected events are queued at drive time and popped on evt.
module tb_enc_8to3_sync;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] in_raw = 8'h00;
  logic [2:0] code;
  logic       valid;
  logic       evt;
  logic       evt_pending;
  logic [7:0] stable_vec;

  typedef struct {
    logic [3:0] vc;
    int         due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  enc_8to3_sync #(
    .DEB_CYCLES (4),
    .CNT_W      (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_raw      (in_raw),
    .ack         (ack),
    .code        (code),
    .valid       (valid),
    .evt         (evt),
    .evt_pending (evt_pending),
    .stable_vec  (stable_vec)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: sim time limit hit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (evt) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_evt: got evt code=%0d valid=%0d cyc=%0d, required no evt",
                   code, valid, cyc);
        end else begin
          mon_e = sbq.pop_front();
          checks++;
          if ({valid, code} !== mon_e.vc) begin
            errors++;
            $display("FAIL evt_value: got {valid,code}=%b, required %b",
                     {valid, code}, mon_e.vc);
          end
          if (cyc != mon_e.due) begin
            errors++;
            $display("FAIL evt_latency: got cycle %0d, required %0d", cyc, mon_e.due);
          end
        end
      end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
        checks++;
        errors++;
        $display("FAIL evt_missing: no evt by cycle %0d, required at %0d value %b",
                 cyc, sbq[0].due, sbq[0].vc);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic drive(input logic [7:0] v, input logic [3:0] vc, input bit exp_evt);
    exp_t e;
    @(negedge clk);
    #1;
    in_raw = v;
    if (exp_evt) begin
      e.vc  = vc;
      e.due = cyc + 8;
      sbq.push_back(e);
    end
  endtask

  task automatic pulse_ack;
    @(negedge clk);
    #1 ack = 1'b1;
    @(negedge clk);
    #1 ack = 1'b0;
  endtask

  task automatic test_reset;
    exp_t e;
    rst_n  = 1'b0;
    in_raw = 8'hFF;
    repeat (3) @(negedge clk);
    checks++;
    if ({code, valid, evt, evt_pending, stable_vec} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got code=%0d valid=%0d evt=%0d pend=%0d stab=%h, required all 0",
               code, valid, evt, evt_pending, stable_vec);
    end
    #1 rst_n = 1'b1;
    e.vc  = 4'b1111;
    e.due = cyc + 8;
    sbq.push_back(e);
    repeat (10) @(negedge clk);
    checks++;
    if (evt_pending !== 1'b1) begin
      errors++;
      $display("FAIL reset_pending: got %b, required 1", evt_pending);
    end
    pulse_ack();
    checks++;
    if (evt_pending !== 1'b0) begin
      errors++;
      $display("FAIL ack_clear: got %b, required 0", evt_pending);
    end
  endtask

  task automatic test_priority;
    drive(8'h00, 4'b0000, 1'b1);
    repeat (12) @(negedge clk);
    pulse_ack();
    drive(8'h4A, 4'b1110, 1'b1);
    repeat (7) @(negedge clk);
    checks++;
    if ({evt, evt_pending} !== 2'b00) begin
      errors++;
      $display("FAIL prio_early: got evt=%b pend=%b, required 0 0", evt, evt_pending);
    end
    @(negedge clk);
    checks++;
    if ({evt_pending, valid, code} !== 5'b11110) begin
      errors++;
      $display("FAIL prio_4a: got pend=%b valid=%b code=%0d, required 1 1 6",
               evt_pending, valid, code);
    end
    @(negedge clk);
    checks++;
    if (evt !== 1'b0) begin
      errors++;
      $display("FAIL evt_width: got evt=%b a cycle later, required 0", evt);
    end
    pulse_ack();
    drive(8'h01, 4'b1000, 1'b1);
    repeat (12) @(negedge clk);
    checks++;
    if ({valid, code} !== 4'b1000) begin
      errors++;
      $display("FAIL prio_01: got valid=%b code=%0d, required 1 0", valid, code);
    end
  endtask

  task automatic test_glitch;
    bit bad;
    drive(8'h00, 4'b0000, 1'b1);
    repeat (12) @(negedge clk);
    pulse_ack();
    drive(8'h08, 4'b0000, 1'b0);
    repeat (2) @(negedge clk);
    drive(8'h00, 4'b0000, 1'b0);
    bad = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (stable_vec !== 8'h00) bad = 1'b1;
    end
    checks++;
    if (bad || {valid, code} !== 4'b0000) begin
      errors++;
      $display("FAIL glitch_short: got stab_seen_nonzero=%b valid=%b code=%0d, required 0 0 0",
               bad, valid, code);
    end
    drive(8'h08, 4'b1011, 1'b1);
    repeat (4) @(negedge clk);
    drive(8'h00, 4'b0000, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if ({valid, code} !== 4'b1011) begin
      errors++;
      $display("FAIL glitch_long: got valid=%b code=%0d, required 1 3", valid, code);
    end
    repeat (10) @(negedge clk);
    pulse_ack();
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 6; i++) begin
      drive((i % 2 == 0) ? 8'h20 : 8'h00, 4'b0000, 1'b0);
      @(negedge clk);
    end
    drive(8'h20, 4'b1101, 1'b1);
    repeat (6) @(negedge clk);
    checks++;
    if (stable_vec !== 8'h00) begin
      errors++;
      $display("FAIL bounce_early: got stab=%h, required 00", stable_vec);
    end
    @(negedge clk);
    checks++;
    if (stable_vec !== 8'h20) begin
      errors++;
      $display("FAIL bounce_settle: got stab=%h, required 20", stable_vec);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_handshake;
    pulse_ack();
    drive(8'h00, 4'b0000, 1'b1);
    repeat (8) @(negedge clk);
    checks++;
    if (evt !== 1'b1) begin
      errors++;
      $display("FAIL hs_evt: got evt=%b, required 1", evt);
    end
    #1 ack = 1'b1;
    @(negedge clk);
    checks++;
    if (evt_pending !== 1'b1) begin
      errors++;
      $display("FAIL hs_same_cycle: got pend=%b, required 1", evt_pending);
    end
    @(negedge clk);
    checks++;
    if (evt_pending !== 1'b0) begin
      errors++;
      $display("FAIL hs_late_ack: got pend=%b, required 0", evt_pending);
    end
    @(negedge clk);
    checks++;
    if ({evt_pending, valid, code} !== 5'b00000) begin
      errors++;
      $display("FAIL hs_idle_ack: got pend=%b valid=%b code=%0d, required 0 0 0",
               evt_pending, valid, code);
    end
    #1 ack = 1'b0;
  endtask

  task automatic test_no_change;
    drive(8'h80, 4'b1111, 1'b1);
    repeat (12) @(negedge clk);
    pulse_ack();
    drive(8'hC0, 4'b0000, 1'b0);
    repeat (12) @(negedge clk);
    checks++;
    if ({stable_vec, valid, code, evt_pending} !== {8'hC0, 1'b1, 3'd7, 1'b0}) begin
      errors++;
      $display("FAIL no_change: got stab=%h valid=%b code=%0d pend=%b, required c0 1 7 0",
               stable_vec, valid, code, evt_pending);
    end
    drive(8'h00, 4'b0000, 1'b1);
    repeat (12) @(negedge clk);
    checks++;
    if ({stable_vec, valid, code, evt_pending} !== {8'h00, 1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL all_zero: got stab=%h valid=%b code=%0d pend=%b, required 00 0 0 1",
               stable_vec, valid, code, evt_pending);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_glitch();
    test_bounce();
    test_handshake();
    test_no_change();
    repeat (5) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending entries, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
